bitserial_seq_ctrl: RTL and testbench

//  Sequencer for the 1-bit compute slice of the logic processor. It owns two
//  N-bit operand shift registers (A, B), loaded from switches. On Execute it

---
 rtl/bitserial_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_bitserial_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitserial_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bitserial_seq_ctrl
// Summary  : Sequencer for a 1-bit compute slice. It streams two N-bit operand
//            registers LSB-first for N cycles and writes the result back
//            according to the routing code.
// Revision : 1.0 - initial release
// ============================================================================
module bitserial_seq_ctrl #(
    parameter int N = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Execute,
    input  logic         LoadA,
    input  logic         LoadB,
    input  logic [N-1:0] Din,
    input  logic [2:0]   F,
    input  logic [1:0]   R,
    output logic [2:0]   slice_F,
    output logic         slice_A,
    output logic         slice_B,
    input  logic         slice_FAB,
    output logic [N-1:0] A_Out,
    output logic [N-1:0] B_Out,
    output logic         Busy,
    output logic         Done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_f;
    logic [1:0]    r_r;
    logic          r_busy;
    logic          r_done;

    logic          w_new_a;
    logic          w_new_b;

    // Bit shifted into the MSB of each register; routing is latched at start.
    always_comb begin
        w_new_a = r_a[0];
        w_new_b = r_b[0];
        case (r_r)
            2'b00: begin w_new_a = r_a[0];    w_new_b = r_b[0];    end
            2'b01: begin w_new_a = r_a[0];    w_new_b = slice_FAB; end
            2'b10: begin w_new_a = slice_FAB; w_new_b = r_b[0];    end
            2'b11: begin w_new_a = r_b[0];    w_new_b = r_a[0];    end
            default: begin w_new_a = r_a[0]; w_new_b = r_b[0]; end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_f     <= 3'b000;
            r_r     <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A start request takes priority over any pending load.
                    if (Execute) begin
                        r_state <= S_SHIFT;
                        r_f     <= F;
                        r_r     <= R;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        if (LoadA) r_a <= Din;
                        if (LoadB) r_b <= Din;
                    end
                end
                S_SHIFT: begin
                    r_a <= {w_new_a, r_a[N-1:1]};
                    r_b <= {w_new_b, r_b[N-1:1]};
                    if (r_cnt == c_cnt_last) begin
                        r_state <= S_HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    // Wait for the request to drop so one press gives one op.
                    if (!Execute) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign slice_F = r_f;
    assign slice_A = r_a[0];
    assign slice_B = r_b[0];
    assign A_Out   = r_a;
    assign B_Out   = r_b;
    assign Busy    = r_busy;
    assign Done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bitserial_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitserial_seq_ctrl
// Summary  : Directed self-checking bench for bitserial_seq_ctrl (N=8) with a
//            behavioural model of the 1-bit logic slice.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitserial_seq_ctrl;

    localparam int N = 8;

    logic         Clk;
    logic         Reset_n;
    logic         Execute;
    logic         LoadA;
    logic         LoadB;
    logic [N-1:0] Din;
    logic [2:0]   F;
    logic [1:0]   R;
    logic [2:0]   slice_F;
    logic         slice_A;
    logic         slice_B;
    logic         slice_FAB;
    logic [N-1:0] A_Out;
    logic [N-1:0] B_Out;
    logic         Busy;
    logic         Done;

    int n_pass;
    int n_total;

    bitserial_seq_ctrl #(.N(N)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Execute   (Execute),
        .LoadA     (LoadA),
        .LoadB     (LoadB),
        .Din       (Din),
        .F         (F),
        .R         (R),
        .slice_F   (slice_F),
        .slice_A   (slice_A),
        .slice_B   (slice_B),
        .slice_FAB (slice_FAB),
        .A_Out     (A_Out),
        .B_Out     (B_Out),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Slice: AND, OR, XOR, one, NAND, NOR, XNOR, zero
    always_comb begin
        case (slice_F)
            3'b000: slice_FAB = slice_A & slice_B;
            3'b001: slice_FAB = slice_A | slice_B;
            3'b010: slice_FAB = slice_A ^ slice_B;
            3'b011: slice_FAB = 1'b1;
            3'b100: slice_FAB = ~(slice_A & slice_B);
            3'b101: slice_FAB = ~(slice_A | slice_B);
            3'b110: slice_FAB = ~(slice_A ^ slice_B);
            default: slice_FAB = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_ab(input logic [N-1:0] a, input logic [N-1:0] b);
        Din = a; LoadA = 1'b1; tick(); LoadA = 1'b0;
        Din = b; LoadB = 1'b1; tick(); LoadB = 1'b0;
    endtask

    // One Execute pulse; returns in HOLD with Execute low, or on timeout.
    task automatic run_op(input logic [2:0] f, input logic [1:0] r,
                          output int busy_cnt, output bit done_seen);
        F = f; R = r; Execute = 1'b1;
        tick();
        Execute = 1'b0;
        busy_cnt  = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 20 && !done_seen; i++) begin
            if (Busy) busy_cnt++;
            if (Done) done_seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Execute = 1'b0; LoadA = 1'b0; LoadB = 1'b0;
        Din = '0; F = 3'b000; R = 2'b00;
        tick(); tick();
        n_total++;
        if ({A_Out, B_Out, Busy, Done, slice_F} !== {16'h0000, 1'b0, 1'b0, 3'b000})
            $display("FAIL reset_state: got A=%h B=%h Busy=%b Done=%b F=%b, want all zero", A_Out, B_Out, Busy, Done, slice_F);
        else n_pass++;
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_and_route_a();
        int bc; bit ds;
        load_ab(8'h33, 8'h55);
        n_total++;
        if ({A_Out, B_Out} !== 16'h3355) $display("FAIL load: got A=%h B=%h, want 33 55", A_Out, B_Out);
        else n_pass++;
        run_op(3'b000, 2'b10, bc, ds);
        n_total++;
        if (!ds || A_Out !== 8'h11 || B_Out !== 8'h55)
            $display("FAIL and_r10: got done=%b A=%h B=%h, want 1 11 55", ds, A_Out, B_Out);
        else n_pass++;
        n_total++;
        if (bc !== 8 || Busy !== 1'b0) $display("FAIL busy_len: got %0d cycles busy_now=%b, want 8 0", bc, Busy);
        else n_pass++;
        tick();
        n_total++;
        if (Done !== 1'b0 || Busy !== 1'b0) $display("FAIL hold_exit: got Done=%b Busy=%b, want 0 0", Done, Busy);
        else n_pass++;
    endtask

    task automatic test_xor_and_one();
        int bc; bit ds;
        load_ab(8'h33, 8'h55);
        run_op(3'b010, 2'b01, bc, ds);
        n_total++;
        if (!ds || A_Out !== 8'h33 || B_Out !== 8'h66)
            $display("FAIL xor_r01: got done=%b A=%h B=%h, want 1 33 66", ds, A_Out, B_Out);
        else n_pass++;
        tick();
        run_op(3'b011, 2'b10, bc, ds);
        n_total++;
        if (!ds || A_Out !== 8'hFF || B_Out !== 8'h66)
            $display("FAIL one_r10: got done=%b A=%h B=%h, want 1 ff 66", ds, A_Out, B_Out);
        else n_pass++;
        tick();
    endtask

    task automatic test_swap_rotate();
        int bc; bit ds;
        load_ab(8'h33, 8'h55);
        run_op(3'b001, 2'b11, bc, ds);
        n_total++;
        if (!ds || A_Out !== 8'h55 || B_Out !== 8'h33)
            $display("FAIL swap_r11: got done=%b A=%h B=%h, want 1 55 33", ds, A_Out, B_Out);
        else n_pass++;
        tick();
        load_ab(8'h33, 8'h55);
        run_op(3'b001, 2'b00, bc, ds);
        n_total++;
        if (!ds || A_Out !== 8'h33 || B_Out !== 8'h55)
            $display("FAIL rotate_r00: got done=%b A=%h B=%h, want 1 33 55", ds, A_Out, B_Out);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int bc; bit ds;
        int busy_cnt;
        int done_cnt;
        load_ab(8'h33, 8'h55);
        F = 3'b010; R = 2'b10; Execute = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (Busy) busy_cnt++;
            if (Done) done_cnt++;
        end
        n_total++;
        if (busy_cnt !== 8 || done_cnt !== 22 || A_Out !== 8'h66)
            $display("FAIL held_exec: got busy=%0d done=%0d A=%h, want 8 22 66", busy_cnt, done_cnt, A_Out);
        else n_pass++;
        Execute = 1'b0;
        tick();
        n_total++;
        if (Done !== 1'b0 || Busy !== 1'b0) $display("FAIL release_idle: got Done=%b Busy=%b, want 0 0", Done, Busy);
        else n_pass++;
        run_op(3'b010, 2'b10, bc, ds);
        n_total++;
        if (!ds || bc !== 8 || A_Out !== 8'h33 || B_Out !== 8'h55)
            $display("FAIL second_press: got done=%b busy=%0d A=%h B=%h, want 1 8 33 55", ds, bc, A_Out, B_Out);
        else n_pass++;
        tick();
    endtask

    task automatic test_ignored_inputs();
        int bc; bit ds;
        bit f_bad;
        load_ab(8'h33, 8'h55);
        F = 3'b000; R = 2'b10; Execute = 1'b1;
        tick();
        Execute = 1'b0;
        LoadA = 1'b1; Din = 8'hAA; F = 3'b001; R = 2'b11;
        ds = 1'b0; f_bad = 1'b0;
        for (int i = 0; i < 20 && !ds; i++) begin
            if (slice_F !== 3'b000) f_bad = 1'b1;
            if (Done) ds = 1'b1;
            else tick();
        end
        n_total++;
        if (!ds || f_bad || A_Out !== 8'h11 || B_Out !== 8'h55)
            $display("FAIL midop_ignore: got done=%b fchg=%b A=%h B=%h, want 1 0 11 55", ds, f_bad, A_Out, B_Out);
        else n_pass++;
        LoadA = 1'b0;
        tick();
        Din = 8'h0F; LoadA = 1'b1; LoadB = 1'b1;
        tick();
        LoadA = 1'b0; LoadB = 1'b0;
        n_total++;
        if (A_Out !== 8'h0F || B_Out !== 8'h0F) $display("FAIL load_both: got A=%h B=%h, want 0f 0f", A_Out, B_Out);
        else n_pass++;
        // Execute and LoadA on the same IDLE edge: load must lose
        Din = 8'hAA; LoadA = 1'b1; F = 3'b000; R = 2'b00; Execute = 1'b1;
        tick();
        Execute = 1'b0; LoadA = 1'b0;
        n_total++;
        if (Busy !== 1'b1 || A_Out !== 8'h0F) $display("FAIL exec_wins: got Busy=%b A=%h, want 1 0f", Busy, A_Out);
        else n_pass++;
        bc = 0; ds = 1'b0;
        for (int i = 0; i < 20 && !ds; i++) begin
            if (Done) ds = 1'b1;
            else tick();
        end
        n_total++;
        if (!ds || A_Out !== 8'h0F || B_Out !== 8'h0F)
            $display("FAIL exec_wins_end: got done=%b A=%h B=%h, want 1 0f 0f", ds, A_Out, B_Out);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_midop();
        int bc; bit ds;
        load_ab(8'h33, 8'h55);
        F = 3'b100; R = 2'b10; Execute = 1'b1;
        tick();
        Execute = 1'b0;
        tick(); tick(); tick(); tick();
        Reset_n = 1'b0;
        #1;
        n_total++;
        if ({A_Out, B_Out, Busy, Done, slice_F} !== {16'h0000, 1'b0, 1'b0, 3'b000})
            $display("FAIL midop_reset: got A=%h B=%h Busy=%b Done=%b F=%b, want all zero", A_Out, B_Out, Busy, Done, slice_F);
        else n_pass++;
        #1;
        Reset_n = 1'b1;
        tick();
        n_total++;
        if (Busy !== 1'b0 || Done !== 1'b0) $display("FAIL post_reset_idle: got Busy=%b Done=%b, want 0 0", Busy, Done);
        else n_pass++;
        load_ab(8'h33, 8'h55);
        run_op(3'b010, 2'b01, bc, ds);
        n_total++;
        if (!ds || bc !== 8 || A_Out !== 8'h33 || B_Out !== 8'h66)
            $display("FAIL post_reset_op: got done=%b busy=%0d A=%h B=%h, want 1 8 33 66", ds, bc, A_Out, B_Out);
        else n_pass++;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_and_route_a();
        test_xor_and_one();
        test_swap_rotate();
        test_back_to_back();
        test_ignored_inputs();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
